// File: rtl/if_fetch_stage.sv
// Instruction fetch stage.
// Owns the PC and keeps at most one request outstanding to a variable-latency
// instruction memory. It presents {PC, instruction, valid} to the IF/ID register.
// A one-entry skid buffer absorbs a response that lands while IF/ID is stalled.
// EX-stage redirects flush the presented instruction. A request that is still in
// flight at redirect time is drained and its data thrown away (DISCARD state).
module if_fetch_stage #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  NOP      = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             STALL,
  input  logic             REDIRECT,
  input  logic [WIDTH-1:0] REDIRECT_PC,
  output logic             IMEM_REQ,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic [WIDTH-1:0] IMEM_RDATA,
  input  logic             IMEM_VALID,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] INSTRUCTION_OUT,
  output logic             FETCH_VALID
);

  localparam logic [1:0] ST_FETCH   = 2'd0;  // request outstanding, waiting for data
  localparam logic [1:0] ST_HOLD    = 2'd1;  // response parked in skid, IF/ID stalled
  localparam logic [1:0] ST_DISCARD = 2'd2;  // draining a request made stale by a redirect

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;         // architectural fetch PC (redirect target while draining)
  logic [WIDTH-1:0] skid_addr;
  logic [WIDTH-1:0] skid_data;

  logic             state_legal;
  logic [WIDTH-1:0] redirect_tgt;
  logic [WIDTH-1:0] addr_inc;
  logic [WIDTH-1:0] skid_inc;

  // Instructions are word aligned. The two low target bits are simply dropped.
  assign redirect_tgt = REDIRECT_PC & ~WIDTH'(3);
  // The PC wraps modulo 2^WIDTH. The carry out is discarded on purpose.
  assign addr_inc     = IMEM_ADDR + WIDTH'(4);
  assign skid_inc     = skid_addr + WIDTH'(4);
  assign state_legal  = (state == ST_FETCH) || (state == ST_HOLD) || (state == ST_DISCARD);

  // The request is held while a fetch or a drain is outstanding. It is masked by
  // reset so the memory never sees a request during reset.
  assign IMEM_REQ = ((state == ST_FETCH) || (state == ST_DISCARD)) && !rst;

  // Fetch state machine, PC/address registers, skid buffer and IF/ID-facing outputs.
  // NOTE: every register here uses non-blocking assignments, so all the branches below
  // read the pre-edge values of state, IMEM_ADDR and skid_* regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || !state_legal) begin
      state           <= ST_FETCH;
      pc              <= RESET_PC;
      IMEM_ADDR       <= RESET_PC;
      PC_OUT          <= '0;
      INSTRUCTION_OUT <= NOP;
      FETCH_VALID     <= 1'b0;
      // NOTE: the skid is only two words of flops. Clearing it on reset costs nothing and
      // guarantees that no pre-reset instruction can ever be replayed.
      skid_addr       <= '0;
      skid_data       <= '0;
    end else if (REDIRECT) begin
      // A redirect beats a stall. The presented instruction is on the wrong path.
      pc              <= redirect_tgt;
      FETCH_VALID     <= 1'b0;
      INSTRUCTION_OUT <= NOP;
      skid_addr       <= '0;
      skid_data       <= '0;
      case (state)
        ST_FETCH: begin
          if (IMEM_VALID) begin
            // The response arrives this very edge. Drop it and start the target fetch.
            IMEM_ADDR <= redirect_tgt;
          end else begin
            // The old request is still in flight. IMEM_ADDR must stay stable until it completes.
            state <= ST_DISCARD;
          end
        end
        ST_HOLD: begin
          state     <= ST_FETCH;
          IMEM_ADDR <= redirect_tgt;
        end
        default: begin
          // ST_DISCARD: keep draining. Only the target changes.
          state <= ST_DISCARD;
        end
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (IMEM_VALID) begin
            if (!STALL) begin
              PC_OUT          <= IMEM_ADDR;
              INSTRUCTION_OUT <= IMEM_RDATA;
              FETCH_VALID     <= 1'b1;
              pc              <= addr_inc;
              IMEM_ADDR       <= addr_inc;
            end else begin
              skid_addr <= IMEM_ADDR;
              skid_data <= IMEM_RDATA;
              state     <= ST_HOLD;
            end
          end else if (!STALL) begin
            // Nothing to hand over this edge. Insert a bubble and keep PC_OUT.
            FETCH_VALID     <= 1'b0;
            INSTRUCTION_OUT <= NOP;
          end
        end
        ST_HOLD: begin
          if (!STALL) begin
            PC_OUT          <= skid_addr;
            INSTRUCTION_OUT <= skid_data;
            FETCH_VALID     <= 1'b1;
            pc              <= skid_inc;
            IMEM_ADDR       <= skid_inc;
            state           <= ST_FETCH;
          end
        end
        default: begin
          // ST_DISCARD: the outputs are already a bubble from the redirect.
          if (IMEM_VALID) begin
            IMEM_ADDR <= pc;
            state     <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage.
// The directed stimulus pushes the instructions it expects IF/ID to consume into a
// queue. A monitor pops that queue whenever an instruction is consumed (FETCH_VALID=1,
// STALL=0, rst=0 at the upcoming edge). A small memory model answers each request a
// programmable number of cycles after it is first seen.
// Timing within each cycle:
//   negedge + 0: stimulus drives the inputs
//   negedge + 1: the memory responds
//   negedge + 2: the monitor samples
//   negedge + 3: the stimulus makes its point checks
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = '0;
  logic        IMEM_VALID = 1'b0;
  logic [31:0] PC_OUT;
  logic [31:0] INSTRUCTION_OUT;
  logic        FETCH_VALID;

  int   errors = 0;
  int   checks = 0;
  int   lat = 1;
  int   mem_cnt = 0;
  exp_t exp_q[$];

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .STALL           (STALL),
    .REDIRECT        (REDIRECT),
    .REDIRECT_PC     (REDIRECT_PC),
    .IMEM_REQ        (IMEM_REQ),
    .IMEM_ADDR       (IMEM_ADDR),
    .IMEM_RDATA      (IMEM_RDATA),
    .IMEM_VALID      (IMEM_VALID),
    .PC_OUT          (PC_OUT),
    .INSTRUCTION_OUT (INSTRUCTION_OUT),
    .FETCH_VALID     (FETCH_VALID)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is its own address XOR a fixed tag.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Holds rst for two edges, checks the reset state and releases rst at a negedge.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    STALL = 1'b0;
    REDIRECT = 1'b0;
    @(negedge clk);
    #3;
    check1("rst_req", IMEM_REQ, 1'b0);
    check("rst_pc_out", PC_OUT, 32'h0);
    check("rst_instr", INSTRUCTION_OUT, NOP);
    check1("rst_valid", FETCH_VALID, 1'b0);
    check("rst_addr", IMEM_ADDR, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory model: answers a request lat cycles after the request is first seen.
  // Reset or a dropped request abandons the count.
  initial begin : memory
    forever begin
      @(negedge clk);
      #1;
      if (rst || !IMEM_REQ) begin
        IMEM_VALID = 1'b0;
        mem_cnt    = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt >= lat) begin
          IMEM_VALID = 1'b1;
          IMEM_RDATA = word_of(IMEM_ADDR);
          mem_cnt    = 0;
        end else begin
          IMEM_VALID = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every instruction consumed by IF/ID must be the next expected one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && FETCH_VALID && !STALL) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required no instruction", PC_OUT,
                   INSTRUCTION_OUT);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", PC_OUT, e.pc);
          check("sb_instr", INSTRUCTION_OUT, e.instr);
        end
      end
    end
  end

  initial begin : stimulus
    // Test 1: 1-cycle memory, no stall, so one instruction per cycle.
    lat = 1;
    apply_reset();
    expect_instr(32'h0);
    expect_instr(32'h4);
    expect_instr(32'h8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      check1("t1_req", IMEM_REQ, 1'b1);
      check("t1_addr", IMEM_ADDR, 32'(4 * i));
      if (i > 0) begin
        check("t1_pc_out", PC_OUT, 32'(4 * (i - 1)));
        check1("t1_valid", FETCH_VALID, 1'b1);
      end
    end
    check_drained("t1_drained");

    // Test 2: 3-cycle memory, giving two bubbles between valid instructions.
    lat = 3;
    apply_reset();
    expect_instr(32'h0);
    expect_instr(32'h4);
    expect_instr(32'h8);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      check1("t2_req", IMEM_REQ, 1'b1);
      check("t2_addr", IMEM_ADDR, 32'(4 * (c / 3)));
      check1("t2_valid", FETCH_VALID, (c >= 3) && (c % 3 == 0));
      if (c == 4 || c == 8) begin
        check("t2_bubble_instr", INSTRUCTION_OUT, NOP);
        check("t2_bubble_pc", PC_OUT, 32'(4 * ((c / 3) - 1)));
      end
    end
    check_drained("t2_drained");

    // Test 3: 4-cycle stall. The response for 0x8 arrives mid-stall and goes to the skid.
    lat = 2;
    apply_reset();
    expect_instr(32'h0);
    expect_instr(32'h4);
    expect_instr(32'h8);
    expect_instr(32'hC);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      STALL = (c >= 4) && (c <= 7);
      #3;
      if (c >= 4 && c <= 7) begin
        check("t3_frozen_pc", PC_OUT, 32'h4);
        check1("t3_frozen_valid", FETCH_VALID, 1'b1);
      end
      if (c == 5) check("t3_addr_8", IMEM_ADDR, 32'h8);
      if (c == 6 || c == 7) check1("t3_hold_req", IMEM_REQ, 1'b0);
      if (c == 9) begin
        check("t3_release_pc", PC_OUT, 32'h8);
        check("t3_next_addr", IMEM_ADDR, 32'hC);
        check1("t3_next_req", IMEM_REQ, 1'b1);
      end
    end
    STALL = 1'b0;
    check_drained("t3_drained");

    // Test 4: redirect to 0x103 while the request to 0x10 is still pending.
    lat = 2;
    apply_reset();
    expect_instr(32'h0);
    expect_instr(32'h4);
    expect_instr(32'h8);
    expect_instr(32'hC);
    expect_instr(32'h100);
    REDIRECT_PC = 32'h0000_0103;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      REDIRECT = (c == 8);
      #3;
      if (c == 8) check("t4_pending_addr", IMEM_ADDR, 32'h10);
      if (c == 9) begin
        check1("t4_flush_valid", FETCH_VALID, 1'b0);
        check("t4_flush_instr", INSTRUCTION_OUT, NOP);
        check("t4_drain_addr", IMEM_ADDR, 32'h10);
        check1("t4_drain_req", IMEM_REQ, 1'b1);
      end
      if (c == 10) begin
        check("t4_target_addr", IMEM_ADDR, 32'h100);
        check1("t4_drop_valid", FETCH_VALID, 1'b0);
      end
    end
    check_drained("t4_drained");

    // Test 5: redirect, response and stall all in the same cycle. Then the PC wraps.
    lat = 1;
    apply_reset();
    expect_instr(32'hFFFF_FFFC);
    expect_instr(32'h0);
    REDIRECT_PC = 32'hFFFF_FFFE;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      STALL    = (c == 1);
      REDIRECT = (c == 1);
      #3;
      if (c == 2) begin
        check1("t5_flush_valid", FETCH_VALID, 1'b0);
        check("t5_flush_instr", INSTRUCTION_OUT, NOP);
        check("t5_target_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        check1("t5_target_req", IMEM_REQ, 1'b1);
      end
      if (c == 3) begin
        check("t5_wrap_addr", IMEM_ADDR, 32'h0);
        check("t5_top_pc", PC_OUT, 32'hFFFF_FFFC);
      end
    end
    check_drained("t5_drained");

    // Test 6a: reset while in HOLD with a full skid.
    lat = 1;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      STALL = (c >= 1);
      #3;
      if (c == 2) begin
        check1("t6a_hold_req", IMEM_REQ, 1'b0);
        check("t6a_hold_pc", PC_OUT, 32'h0);
      end
    end
    expect_instr(32'h0);
    apply_reset();
    #3;
    check("t6a_restart_addr", IMEM_ADDR, RESET_PC);
    check1("t6a_restart_req", IMEM_REQ, 1'b1);
    @(negedge clk);
    #3;
    check_drained("t6a_drained");

    // Test 6b: reset while in DISCARD. The first request afterwards is at RESET_PC.
    lat = 3;
    apply_reset();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h0000_0040;
    #3;
    @(negedge clk);
    REDIRECT = 1'b0;
    #3;
    check1("t6b_drain_req", IMEM_REQ, 1'b1);
    check("t6b_drain_addr", IMEM_ADDR, 32'h0);
    check1("t6b_drain_valid", FETCH_VALID, 1'b0);
    lat = 1;
    expect_instr(32'h0);
    apply_reset();
    #3;
    check("t6b_restart_addr", IMEM_ADDR, RESET_PC);
    check1("t6b_restart_req", IMEM_REQ, 1'b1);
    @(negedge clk);
    #3;
    check_drained("t6b_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
